snake_cpu_cpu_mul_combine: RTL and testbench
============================================

SNAKE_CPU_CPU_MUL_COMBINE -- requirements
Module: snake_cpu_cpu_mul_combine

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning: 1 = registered W-stage result (latency 2); 0 = combinational result from A stage (latency 1).
REQ-002 Port: clk, input, 1, sole clock; all state on rising edge.
REQ-003 Port: reset, input, 1, reset; synchronous and active-high.
REQ-004 Port: M_mul_cell_p1..p4, input, 32 each, registered 16x16 partial products from the multiplier cell: lo*lo, lo*hi, hi*lo, hi*hi.
REQ-005 Port: M_ctrl_mul_src1_signed / M_ctrl_mul_src2_signed, input, 1 each, operand signedness, aligned with the partial products.
REQ-006 Port: M_ctrl_mul_hi, input, 1, select the upper 32 product bits (mulx*) instead of the lower 32 (mul).
REQ-007 Port: M_valid, input, 1, M-stage multiply instruction is live.
REQ-008 Port: A_en, input, 1, advances the M->A register.
REQ-009 Port: W_en, input, 1, advances the A->W register.
REQ-010 Port: mul_result, output, 32, selected product word.
REQ-011 Port: mul_result_valid, output, 1, mul_result is live for the final stage.
REQ-012 Port: mul_full, output, 64, complete product, for debug/trace.

Function
REQ-013 Stage 1 (M->A, load when A_en=1) SHALL capture:
- p1 (zero-extended).
- mid = sx2(p2) + sx3(p3) as 34-bit.
- p4.
- hi select.
- valid = M_valid.
REQ-014 Extension rules SHALL be:
- sx2 sign-extends p2 iff src2_signed, else zero-extends.
- sx3 sign-extends p3 iff src1_signed, else zero-extends.
REQ-015 Full product SHALL be full[63:0] = p1 + (mid << 16) + (p4 << 32), taken modulo 2^64.
REQ-016 Result selection SHALL be mul_result = hi ? full[63:32] : full[31:0].
REQ-017 Stage 2 (A->W, present only if OUT_REG=1) SHALL load full, mul_result and valid when W_en=1.
REQ-018 When an enable is 0, the stage it drives SHALL hold all of its contents, valid included (stall).
REQ-019 A_en=1 with M_valid=0 SHALL load valid=0 (bubble); the data fields are don't-care but still loaded.
REQ-020 Simultaneous A_en=1 and W_en=1 SHALL move both stages in the same cycle, with no bubble inserted.
REQ-021 W_en=1 with A_en=0 SHALL copy the held stage-1 contents into stage 2; the pipeline controller guarantees no duplicate retire.
REQ-022 Latency SHALL be:
- OUT_REG=1: 2 enabled edges from M inputs to mul_result.
- OUT_REG=0: 1 enabled edge.
REQ-023 The block SHALL produce no X on any output after reset, regardless of the partial-product inputs.

Reset
REQ-024 While reset=1 at a clock edge, all stage registers SHALL clear to 0, irrespective of the enables.
REQ-025 After reset, outputs SHALL be mul_result=0, mul_full=0, mul_result_valid=0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight products; the first valid output after reset comes from an M_valid sampled after reset deasserts.

Structure
REQ-027 A shared package SHALL hold:
- width constants MUL_PP_W=32, MUL_MID_W=34, MUL_FULL_W=64;
- the stage-1 record typedef: p1, mid, p4, hi, valid.
REQ-028 One sub-module, snake_cpu_cpu_mul_extend, SHALL implement the conditional 32->34 sign/zero extension; it is instantiated twice.
REQ-029 The block SHALL contain no multipliers; it uses adders and registers only.

Verification
The bench models the multiplier cell and drives p1..p4 from operands a and b.
REQ-030 Signed, a=b=0xFFFFFFFF, hi=1 -> full=0x0000000000000001, mul_result=0x00000000.
REQ-031 Unsigned, a=b=0xFFFFFFFF, hi=1 -> mul_result=0xFFFFFFFE; with hi=0 -> mul_result=0x00000001.
REQ-032 src1 signed, src2 unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF, hi=1 -> full=0xFFFFFFFF00000001, mul_result=0xFFFFFFFF.
REQ-033 Signed, a=b=0x80000000 -> full=0x4000000000000000; back-to-back issue every cycle -> one result per cycle at latency 2.
REQ-034 Stall W_en=0 for 3 cycles with a valid product in A -> outputs and valid frozen; then release -> correct value retires exactly once.
REQ-035 Assert reset for 1 cycle while 2 products are in flight -> mul_result_valid=0 and mul_result=0 on the next cycle; neither product appears afterwards.

Source files
------------

// File: rtl/snake_cpu_cpu_mul_combine_pkg.sv
// Shared widths and stage records for the multiply partial-product combiner.
// The combiner folds four 16x16 partial products into a 64-bit product.
package snake_cpu_cpu_mul_combine_pkg;

    localparam int MUL_PP_W   = 32;
    localparam int MUL_MID_W  = 34;
    localparam int MUL_FULL_W = 64;
    localparam int MUL_RES_W  = 32;

    // M->A stage record: cross terms are already summed into mid
    typedef struct packed {
        logic [MUL_PP_W-1:0]         p1;
        logic signed [MUL_MID_W-1:0] mid;
        logic [MUL_PP_W-1:0]         p4;
        logic                        hi;
        logic                        valid;
    } mul_st1_t;

    // A->W stage record
    typedef struct packed {
        logic [MUL_FULL_W-1:0] full;
        logic [MUL_RES_W-1:0]  result;
        logic                  valid;
    } mul_st2_t;

endpackage

// File: rtl/snake_cpu_cpu_mul_combine_if.sv
// M-stage partial products and controls in, selected product word out.
// master: pipeline side driving the block; slave: the combiner itself.
interface snake_cpu_cpu_mul_combine_if;
    import snake_cpu_cpu_mul_combine_pkg::*;

    logic [MUL_PP_W-1:0]   M_mul_cell_p1;
    logic [MUL_PP_W-1:0]   M_mul_cell_p2;
    logic [MUL_PP_W-1:0]   M_mul_cell_p3;
    logic [MUL_PP_W-1:0]   M_mul_cell_p4;
    logic                  M_ctrl_mul_src1_signed;
    logic                  M_ctrl_mul_src2_signed;
    logic                  M_ctrl_mul_hi;
    logic                  M_valid;
    logic                  A_en;
    logic                  W_en;
    logic [MUL_RES_W-1:0]  mul_result;
    logic                  mul_result_valid;
    logic [MUL_FULL_W-1:0] mul_full;

    modport master (
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
        output M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed, M_ctrl_mul_hi,
        output M_valid, A_en, W_en,
        input  mul_result, mul_result_valid, mul_full
    );

    modport slave (
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
        input  M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed, M_ctrl_mul_hi,
        input  M_valid, A_en, W_en,
        output mul_result, mul_result_valid, mul_full
    );

endinterface

// File: rtl/snake_cpu_cpu_mul_extend.sv
// Widens a 32-bit cross partial product to 34 bits, sign- or zero-extending
// depending on the signedness of the operand that supplied its high half.
module snake_cpu_cpu_mul_extend
    import snake_cpu_cpu_mul_combine_pkg::*;
(
    input  logic [MUL_PP_W-1:0]         din,
    input  logic                        sign_en,
    output logic signed [MUL_MID_W-1:0] dout
);

    logic ext_bit;

    assign ext_bit = sign_en & din[MUL_PP_W-1];
    assign dout    = {{(MUL_MID_W-MUL_PP_W){ext_bit}}, din};

endmodule

// File: rtl/snake_cpu_cpu_mul_combine.sv
// Combines the registered 16x16 partial products into the 64-bit product and
// selects mul/mulx word; optional W-stage register controlled by OUT_REG.
module snake_cpu_cpu_mul_combine
    import snake_cpu_cpu_mul_combine_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input logic                       clk,
    input logic                       reset,
    snake_cpu_cpu_mul_combine_if.slave mul
);

    localparam int MID_EXT_W = MUL_FULL_W - MUL_MID_W;

    // mid is a signed quantity, so it must be sign-extended before shifting
    function automatic logic [MUL_FULL_W-1:0] combine_full(input mul_st1_t st);
        logic signed [MUL_FULL_W-1:0] mid_ext;
        mid_ext = {{MID_EXT_W{st.mid[MUL_MID_W-1]}}, st.mid};
        return {{(MUL_FULL_W-MUL_PP_W){1'b0}}, st.p1}
             + (mid_ext << 16)
             + {st.p4, {(MUL_FULL_W-MUL_PP_W){1'b0}}};
    endfunction

    function automatic logic [MUL_RES_W-1:0] select_word(
        input logic [MUL_FULL_W-1:0] full,
        input logic                  hi
    );
        return hi ? full[MUL_FULL_W-1:MUL_RES_W] : full[MUL_RES_W-1:0];
    endfunction

    logic signed [MUL_MID_W-1:0] p2_x_p0;
    logic signed [MUL_MID_W-1:0] p3_x_p0;
    logic signed [MUL_MID_W-1:0] mid_p0;
    mul_st1_t                    st_p0;
    mul_st1_t                    st_p1;
    mul_st2_t                    res_p1;

    snake_cpu_cpu_mul_extend u_ext_p2 (
        .din     (mul.M_mul_cell_p2),
        .sign_en (mul.M_ctrl_mul_src2_signed),
        .dout    (p2_x_p0)
    );

    snake_cpu_cpu_mul_extend u_ext_p3 (
        .din     (mul.M_mul_cell_p3),
        .sign_en (mul.M_ctrl_mul_src1_signed),
        .dout    (p3_x_p0)
    );

    assign mid_p0 = p2_x_p0 + p3_x_p0;

    always_comb begin
        st_p0       = '0;
        st_p0.p1    = mul.M_mul_cell_p1;
        st_p0.mid   = mid_p0;
        st_p0.p4    = mul.M_mul_cell_p4;
        st_p0.hi    = mul.M_ctrl_mul_hi;
        st_p0.valid = mul.M_valid;
    end

    // ---- M -> A stage boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            st_p1 <= '0;
        end else if (mul.A_en) begin
            st_p1 <= st_p0;
        end
    end

    always_comb begin
        res_p1        = '0;
        res_p1.full   = combine_full(st_p1);
        res_p1.result = select_word(res_p1.full, st_p1.hi);
        res_p1.valid  = st_p1.valid;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            mul_st2_t res_p2;

            // ---- A -> W stage boundary ----
            always_ff @(posedge clk) begin
                if (reset) begin
                    res_p2 <= '0;
                end else if (mul.W_en) begin
                    res_p2 <= res_p1;
                end
            end

            assign mul.mul_full         = res_p2.full;
            assign mul.mul_result       = res_p2.result;
            assign mul.mul_result_valid = res_p2.valid;
        end else begin : g_out_comb
            assign mul.mul_full         = res_p1.full;
            assign mul.mul_result       = res_p1.result;
            assign mul.mul_result_valid = res_p1.valid;
        end
    endgenerate

endmodule

// File: tb/tb_snake_cpu_cpu_mul_combine.sv
// Self-checking bench: models the 16x16 multiplier cell feeding the combiner
// and compares against full-width products and a stage-level pipeline model.
module tb_snake_cpu_cpu_mul_combine;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    typedef struct packed {
        logic [63:0] full;
        logic [31:0] res;
        logic        vld;
    } ref_t;

    ref_t a_m;
    ref_t w_m;

    snake_cpu_cpu_mul_combine_if mi ();

    snake_cpu_cpu_mul_combine #(.OUT_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .mul   (mi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact product, straight 64-bit arithmetic on the extended operands
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s1, input logic s2);
        longint ax;
        longint bx;
        ax = s1 ? longint'($signed(a)) : longint'(a);
        bx = s2 ? longint'($signed(b)) : longint'(b);
        return 64'(ax * bx);
    endfunction

    // Multiplier cell model: lo halves unsigned, hi halves follow operand sign
    task automatic drive_m(input logic [31:0] a, input logic [31:0] b, input logic s1,
                           input logic s2, input logic hi, input logic vld);
        longint al, ah, bl, bh, pp;
        logic [15:0] ahw, bhw;
        ahw = a[31:16];
        bhw = b[31:16];
        al = longint'(a[15:0]);
        bl = longint'(b[15:0]);
        ah = s1 ? longint'($signed(ahw)) : longint'(ahw);
        bh = s2 ? longint'($signed(bhw)) : longint'(bhw);
        pp = al * bl; mi.M_mul_cell_p1 = pp[31:0];
        pp = al * bh; mi.M_mul_cell_p2 = pp[31:0];
        pp = ah * bl; mi.M_mul_cell_p3 = pp[31:0];
        pp = ah * bh; mi.M_mul_cell_p4 = pp[31:0];
        mi.M_ctrl_mul_src1_signed = s1;
        mi.M_ctrl_mul_src2_signed = s2;
        mi.M_ctrl_mul_hi          = hi;
        mi.M_valid                = vld;
    endtask

    task automatic check_out(input string tag, input logic [63:0] full,
                             input logic [31:0] res, input logic vld);
        check_eq({tag, ".full"}, mi.mul_full, full);
        check_eq({tag, ".res"}, 64'(mi.mul_result), 64'(res));
        check_eq({tag, ".vld"}, 64'(mi.mul_result_valid), 64'(vld));
    endtask

    // Issue one product, let it reach W, then compare against constants
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s1, input logic s2, input logic hi,
                           input logic [63:0] exp_full, input logic [31:0] exp_res);
        mi.A_en = 1'b1;
        mi.W_en = 1'b1;
        drive_m(a, b, s1, s2, hi, 1'b1);
        step();
        mi.M_valid = 1'b0;
        step();
        check_out(tag, exp_full, exp_res, 1'b1);
        step();
    endtask

    logic [31:0] sa [5];
    logic [31:0] sb [5];
    logic [63:0] sp [5];
    logic [63:0] p_val;
    logic [63:0] q_val;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        mi.A_en = 1'b1;
        mi.W_en = 1'b1;
        drive_m(32'h1234_5678, 32'h9abc_def0, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_out("reset", 64'h0, 32'h0, 1'b0);
        reset = 1'b0;
        mi.M_valid = 1'b0;

        run_one("ss_m1m1_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1,
                64'h0000_0000_0000_0001, 32'h0000_0000);
        run_one("uu_m1m1_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1,
                64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE);
        run_one("uu_m1m1_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                64'hFFFF_FFFE_0000_0001, 32'h0000_0001);
        run_one("su_m1m1_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1,
                64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF);
        run_one("ss_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0,
                64'h4000_0000_0000_0000, 32'h0000_0000);

        // Back-to-back issue: one signed product per cycle, latency 2
        sa[0] = 32'h8000_0000; sb[0] = 32'h8000_0000;
        for (int i = 1; i < 5; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
        end
        for (int i = 0; i < 5; i++) sp[i] = ref_product(sa[i], sb[i], 1'b1, 1'b1);
        mi.A_en = 1'b1;
        mi.W_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) drive_m(sa[k], sb[k], 1'b1, 1'b1, 1'b0, 1'b1);
            else mi.M_valid = 1'b0;
            step();
            if (k >= 1) check_out("b2b", sp[k-1], sp[k-1][31:0], 1'b1);
        end
        step();
        check_out("b2b_drain", sp[4], sp[4][31:0], 1'b0);

        // Stall: P in W, Q in A, freeze both stages for 3 cycles
        p_val = ref_product(32'h0001_2345, 32'hFFFF_0003, 1'b0, 1'b1);
        q_val = ref_product(32'hDEAD_BEEF, 32'h0000_1001, 1'b1, 1'b0);
        drive_m(32'h0001_2345, 32'hFFFF_0003, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        drive_m(32'hDEAD_BEEF, 32'h0000_1001, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_out("stall_pre", p_val, p_val[63:32], 1'b1);
        mi.A_en = 1'b0;
        mi.W_en = 1'b0;
        drive_m(32'h5555_5555, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("stall_hold", p_val, p_val[63:32], 1'b1);
        end
        mi.A_en = 1'b1;
        mi.W_en = 1'b1;
        mi.M_valid = 1'b0;
        step();
        check_out("stall_release", q_val, q_val[31:0], 1'b1);
        step();
        check_eq("stall_once.vld", 64'(mi.mul_result_valid), 64'h0);

        // Reset with two products in flight
        drive_m(32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive_m(32'h0000_000B, 32'h0000_000D, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        mi.M_valid = 1'b0;
        step();
        check_out("rst_flight", 64'h0, 32'h0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("rst_discard.vld", 64'(mi.mul_result_valid), 64'h0);
        end

        // Randomized run against the stage-level reference model
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_m = '0;
        w_m = '0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            logic rs1, rs2, rhi, rv, rae, rwe;
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            rs1 = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            rhi = 1'($urandom_range(0, 1));
            rv  = 1'($urandom_range(0, 1));
            rae = ($urandom_range(0, 3) != 0);
            rwe = ($urandom_range(0, 3) != 0);
            drive_m(ra, rb, rs1, rs2, rhi, rv);
            mi.A_en = rae;
            mi.W_en = rwe;
            if (rwe) w_m = a_m;
            if (rae) begin
                a_m.full = ref_product(ra, rb, rs1, rs2);
                a_m.res  = rhi ? a_m.full[63:32] : a_m.full[31:0];
                a_m.vld  = rv;
            end
            step();
            check_out("rand", w_m.full, w_m.res, w_m.vld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
